// File: rtl/ysyx_22041211_bus_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_22041211_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  localparam logic [3:0] IF_WMASK = 4'b1111;

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ysyx_22041211_mem_arbiter_if.sv
// Requester and downstream memory signals of the arbiter, bundled as one bus.
interface ysyx_22041211_mem_arbiter_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);

  logic                if_req_i;
  logic [ADDR_LEN-1:0] if_addr_i;
  logic                if_gnt_o;
  logic                if_rvalid_o;
  logic [DATA_LEN-1:0] if_rdata_o;

  logic                ls_req_i;
  logic                ls_wen_i;
  logic [ADDR_LEN-1:0] ls_addr_i;
  logic [DATA_LEN-1:0] ls_wdata_i;
  logic [3:0]          ls_wmask_i;
  logic                ls_gnt_o;
  logic                ls_rvalid_o;
  logic [DATA_LEN-1:0] ls_rdata_o;

  logic                err_o;

  logic                mem_req_o;
  logic                mem_wen_o;
  logic [ADDR_LEN-1:0] mem_addr_o;
  logic [DATA_LEN-1:0] mem_wdata_o;
  logic [3:0]          mem_wmask_o;
  logic                mem_ready_i;
  logic                mem_rvalid_i;
  logic [DATA_LEN-1:0] mem_rdata_i;

  // Arbiter view.
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_wen_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output err_o,
    output mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i
  );

  // Environment view: requesters plus memory bridge.
  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_wen_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  err_o,
    input  mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/ysyx_22041211_rr_arb2.sv
// Two-way round-robin picker: req[0] is the IFU, req[1] the LSU.
module ysyx_22041211_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       prio_q
);

  logic prio_reg;

  // prio=1 favours req[1] on contention; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    if (req[1] && (prio || !req[0])) begin
      gnt = 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      prio_reg <= gnt[0];
    end
  end

  assign prio_q = prio_reg;

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares one memory port between IFU and LSU: round-robin grant, a single
// outstanding transaction and a response watchdog that fabricates an error reply.
module ysyx_22041211_mem_arbiter
  import ysyx_22041211_bus_pkg::*;
#(
  parameter int ADDR_LEN  = 32,
  parameter int DATA_LEN  = 32,
  parameter int TO_CYCLES = 256
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22041211_mem_arbiter_if.slave bus
);

  localparam int WD_W = (TO_CYCLES > 1) ? clog2(TO_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TO_CYCLES == 0) ? 0 : TO_CYCLES - 1);

  state_t              state_reg, state_next;
  owner_t              owner_reg, owner_next;
  logic [WD_W-1:0]     wd_reg;
  logic                mem_req_reg;
  logic                mem_wen_reg;
  logic [ADDR_LEN-1:0] mem_addr_reg;
  logic [DATA_LEN-1:0] mem_wdata_reg;
  logic [3:0]          mem_wmask_reg;

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       prio_ls;
  logic       load;
  logic       accept;
  logic       resp;
  logic       timeout;

  ysyx_22041211_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .prio    (prio_ls),
    .advance (load),
    .gnt     (arb_gnt),
    .prio_q  (prio_ls)
  );

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    arb_req    = 2'b00;
    load       = 1'b0;
    accept     = 1'b0;
    resp       = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Requests are only offered to the picker here, so a grant can never
        // coincide with a response cycle.
        arb_req = {bus.ls_req_i, bus.if_req_i};
        if (arb_gnt != 2'b00) begin
          load       = 1'b1;
          owner_next = arb_gnt[1] ? OWN_LS : OWN_IF;
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ready_i) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          resp       = 1'b1;
          state_next = IDLE;
        end else if ((TO_CYCLES != 0) && (wd_reg == WD_LAST)) begin
          resp       = 1'b1;
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_IF;
      wd_reg        <= '0;
      mem_req_reg   <= 1'b0;
      mem_wen_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wmask_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      if (load) begin
        mem_req_reg   <= 1'b1;
        mem_wen_reg   <= arb_gnt[1] ? bus.ls_wen_i : 1'b0;
        mem_addr_reg  <= arb_gnt[1] ? bus.ls_addr_i : bus.if_addr_i;
        mem_wdata_reg <= arb_gnt[1] ? bus.ls_wdata_i : '0;
        mem_wmask_reg <= arb_gnt[1] ? bus.ls_wmask_i : IF_WMASK;
      end else if (accept) begin
        mem_req_reg <= 1'b0;
      end
      if (accept) begin
        wd_reg <= '0;
      end else if (state_reg == WAIT) begin
        wd_reg <= wd_reg + WD_W'(1);
      end
    end
  end

  // Response routing, indexed like the picker: 0 = IFU, 1 = LSU.
  logic                resp_ok;
  logic [1:0]          owner_onehot;
  logic [1:0]          rvalid_vec;
  logic [DATA_LEN-1:0] rdata_vec [2];

  assign resp_ok      = resp & ~rst;
  assign owner_onehot = {owner_reg == OWN_LS, owner_reg == OWN_IF};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign rvalid_vec[gi] = resp_ok & owner_onehot[gi];
      assign rdata_vec[gi]  = (rvalid_vec[gi] && !timeout) ? bus.mem_rdata_i : '0;
    end
  endgenerate

  assign bus.if_gnt_o    = ~rst & arb_gnt[0];
  assign bus.ls_gnt_o    = ~rst & arb_gnt[1];
  assign bus.if_rvalid_o = rvalid_vec[0];
  assign bus.ls_rvalid_o = rvalid_vec[1];
  assign bus.if_rdata_o  = rdata_vec[0];
  assign bus.ls_rdata_o  = rdata_vec[1];
  assign bus.err_o       = resp_ok & timeout;

  assign bus.mem_req_o   = mem_req_reg;
  assign bus.mem_wen_o   = mem_wen_reg;
  assign bus.mem_addr_o  = mem_addr_reg;
  assign bus.mem_wdata_o = mem_wdata_reg;
  assign bus.mem_wmask_o = mem_wmask_reg;

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter with a transaction-level reference model.
module tb_ysyx_22041211_mem_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22041211_mem_arbiter_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

  ysyx_22041211_mem_arbiter #(
    .ADDR_LEN  (32),
    .DATA_LEN  (32),
    .TO_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_mis = 0;
  bit done  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: a transaction is either absent, waiting for memory acceptance, or
  // accepted and counting cycles towards its reply.
  bit          m_busy = 0, m_owner_ls = 0, m_accepted = 0, m_prio_ls = 1;
  int          m_waited = 0;
  logic        m_req = 0, m_wen = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_wmask = 0;
  logic        e_if_gnt, e_ls_gnt, e_rv, e_err;
  logic [31:0] e_rd;

  initial begin
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      if (!done) begin
        e_if_gnt = 0; e_ls_gnt = 0; e_rv = 0; e_err = 0; e_rd = 0;
        if (!rst) begin
          if (!m_busy) begin
            if (bus.if_req_i || bus.ls_req_i) begin
              e_ls_gnt = bus.ls_req_i && (!bus.if_req_i || m_prio_ls);
              e_if_gnt = !e_ls_gnt;
            end
          end else if (m_accepted) begin
            if (bus.mem_rvalid_i) begin
              e_rv = 1; e_rd = bus.mem_rdata_i;
            end else if (m_waited == TO - 1) begin
              e_rv = 1; e_err = 1;
            end
          end
        end
        check("if_gnt", bus.if_gnt_o, e_if_gnt);
        check("ls_gnt", bus.ls_gnt_o, e_ls_gnt);
        check("if_rvalid", bus.if_rvalid_o, e_rv && !m_owner_ls);
        check("ls_rvalid", bus.ls_rvalid_o, e_rv && m_owner_ls);
        check("if_rdata", bus.if_rdata_o, (e_rv && !m_owner_ls) ? e_rd : 32'h0);
        check("ls_rdata", bus.ls_rdata_o, (e_rv && m_owner_ls) ? e_rd : 32'h0);
        check("err", bus.err_o, e_err);
        check("mem_req", bus.mem_req_o, m_req);
        check("mem_wen", bus.mem_wen_o, m_wen);
        check("mem_addr", bus.mem_addr_o, m_addr);
        check("mem_wdata", bus.mem_wdata_o, m_wdata);
        check("mem_wmask", bus.mem_wmask_o, m_wmask);
        if (rst) begin
          m_busy = 0; m_accepted = 0; m_waited = 0; m_prio_ls = 1;
          m_req = 0; m_wen = 0; m_addr = 0; m_wdata = 0; m_wmask = 0;
        end else if (e_if_gnt || e_ls_gnt) begin
          m_busy = 1; m_accepted = 0; m_owner_ls = e_ls_gnt; m_prio_ls = e_if_gnt;
          m_req = 1;
          m_wen   = e_ls_gnt ? bus.ls_wen_i : 1'b0;
          m_addr  = e_ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
          m_wdata = e_ls_gnt ? bus.ls_wdata_i : 32'h0;
          m_wmask = e_ls_gnt ? bus.ls_wmask_i : 4'b1111;
        end else if (m_busy && !m_accepted) begin
          if (bus.mem_ready_i) begin
            m_accepted = 1; m_req = 0; m_waited = 0;
          end
        end else if (m_busy) begin
          if (e_rv) m_busy = 0;
          else m_waited++;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Starts at posedge+1 with requests driven; returns at the grant negedge.
  task automatic wait_gnt(output logic got_if, output logic got_ls);
    got_if = 0;
    got_ls = 0;
    for (int i = 0; i < 16 && !(got_if || got_ls); i++) begin
      if (i != 0) next_cycle();
      neg();
      got_if = bus.if_gnt_o;
      got_ls = bus.ls_gnt_o;
    end
    check("gnt_seen", got_if | got_ls, 1'b1);
  endtask

  // Starts at the grant negedge; returns at posedge+1 of the IDLE cycle after the reply.
  task automatic serve(input int ready_delay, input logic [31:0] rdata);
    for (int i = 0; i < ready_delay; i++) next_cycle();
    next_cycle(); bus.mem_ready_i = 1;
    next_cycle(); bus.mem_ready_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = rdata;
    next_cycle(); bus.mem_rvalid_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout @%0t: got no finish, want finish", $time);
    $fatal(1, "bench timed out");
  end

  logic gi, gl;

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = 0;
    bus.ls_req_i = 0; bus.ls_wen_i = 0; bus.ls_addr_i = 0; bus.ls_wdata_i = 0; bus.ls_wmask_i = 0;
    bus.mem_ready_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    next_cycle();
    next_cycle();
    rst = 0;
    neg();
    check("rst_mem_req", bus.mem_req_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_if_gnt", bus.if_gnt_o, 1'b0);

    // IFU-only read.
    next_cycle(); bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0000;
    neg();
    check("t1_if_gnt", bus.if_gnt_o, 1'b1);
    check("t1_ls_gnt", bus.ls_gnt_o, 1'b0);
    next_cycle(); bus.if_req_i = 0; bus.mem_ready_i = 1;
    neg();
    check("t1_mem_req", bus.mem_req_o, 1'b1);
    check("t1_mem_addr", bus.mem_addr_o, 32'h8000_0000);
    check("t1_mem_wen", bus.mem_wen_o, 1'b0);
    check("t1_mem_wmask", bus.mem_wmask_o, 4'b1111);
    next_cycle(); bus.mem_ready_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_0413;
    neg();
    check("t1_if_rvalid", bus.if_rvalid_o, 1'b1);
    check("t1_if_rdata", bus.if_rdata_o, 32'h0000_0413);
    check("t1_ls_rvalid", bus.ls_rvalid_o, 1'b0);
    check("t1_err", bus.err_o, 1'b0);
    next_cycle(); bus.mem_rvalid_i = 0;

    // Contention after reset: LSU, IFU, LSU, IFU.
    rst = 1;
    next_cycle(); rst = 0;
    bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0004;
    bus.ls_req_i = 1; bus.ls_wen_i = 0; bus.ls_addr_i = 32'h8000_2000;
    bus.ls_wdata_i = 0; bus.ls_wmask_i = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      wait_gnt(gi, gl);
      check("t2_gnt_ls", gl, (t % 2) == 0);
      check("t2_gnt_if", gi, (t % 2) == 1);
      serve(0, 32'h100 + t);
    end
    bus.if_req_i = 0; bus.ls_req_i = 0;

    // LSU write with memory stalling for three cycles.
    next_cycle();
    bus.ls_req_i = 1; bus.ls_wen_i = 1; bus.ls_addr_i = 32'h8000_1000;
    bus.ls_wdata_i = 32'hDEAD_BEEF; bus.ls_wmask_i = 4'b0011;
    wait_gnt(gi, gl);
    check("t3_gnt_ls", gl, 1'b1);
    next_cycle();
    bus.ls_req_i = 0; bus.ls_wen_i = 0; bus.ls_addr_i = 0; bus.ls_wdata_i = 0; bus.ls_wmask_i = 0;
    for (int i = 0; i < 3; i++) begin
      neg();
      check("t3_mem_req", bus.mem_req_o, 1'b1);
      check("t3_mem_wen", bus.mem_wen_o, 1'b1);
      check("t3_mem_addr", bus.mem_addr_o, 32'h8000_1000);
      check("t3_mem_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
      check("t3_mem_wmask", bus.mem_wmask_o, 4'b0011);
      next_cycle();
    end
    bus.mem_ready_i = 1;
    neg();
    check("t3_mem_req_acc", bus.mem_req_o, 1'b1);
    next_cycle(); bus.mem_ready_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h55;
    neg();
    check("t3_ls_rvalid", bus.ls_rvalid_o, 1'b1);
    check("t3_err", bus.err_o, 1'b0);
    next_cycle(); bus.mem_rvalid_i = 0;
    neg();
    check("t3_ls_rvalid_once", bus.ls_rvalid_o, 1'b0);
    next_cycle();

    // Watchdog timeout, then a late reply in IDLE.
    bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0100;
    wait_gnt(gi, gl);
    check("t4_gnt_if", gi, 1'b1);
    next_cycle(); bus.if_req_i = 0; bus.mem_ready_i = 1;
    next_cycle(); bus.mem_ready_i = 0; bus.mem_rdata_i = 32'hFFFF_FFFF;
    for (int w = 1; w <= 4; w++) begin
      neg();
      check("t4_if_rvalid", bus.if_rvalid_o, w == 4);
      check("t4_err", bus.err_o, w == 4);
      check("t4_if_rdata", bus.if_rdata_o, 32'h0);
      next_cycle();
    end
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1234;
    neg();
    check("t4_late_if_rvalid", bus.if_rvalid_o, 1'b0);
    check("t4_late_ls_rvalid", bus.ls_rvalid_o, 1'b0);
    check("t4_late_err", bus.err_o, 1'b0);
    next_cycle(); bus.mem_rvalid_i = 0;

    // Reset while waiting for an LSU reply.
    bus.ls_req_i = 1; bus.ls_wen_i = 0; bus.ls_addr_i = 32'h8000_3000; bus.ls_wmask_i = 4'b0001;
    wait_gnt(gi, gl);
    check("t5_gnt_ls", gl, 1'b1);
    next_cycle(); bus.ls_req_i = 0; bus.mem_ready_i = 1;
    next_cycle(); bus.mem_ready_i = 0; rst = 1;
    neg();
    check("t5_rst_ls_rvalid", bus.ls_rvalid_o, 1'b0);
    next_cycle(); rst = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77;
    neg();
    check("t5_drop_ls_rvalid", bus.ls_rvalid_o, 1'b0);
    check("t5_drop_if_rvalid", bus.if_rvalid_o, 1'b0);
    check("t5_mem_req", bus.mem_req_o, 1'b0);
    next_cycle(); bus.mem_rvalid_i = 0;
    bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0200;
    bus.ls_req_i = 1; bus.ls_addr_i = 32'h8000_3004; bus.ls_wmask_i = 4'b1111;
    wait_gnt(gi, gl);
    check("t5_contend_ls", gl, 1'b1);
    check("t5_contend_if", gi, 1'b0);
    serve(0, 32'h2222);
    bus.ls_req_i = 0;
    wait_gnt(gi, gl);
    check("t5_then_if", gi, 1'b1);
    serve(0, 32'h3333);
    bus.if_req_i = 0;

    // Request raised in the response cycle is granted one cycle later.
    next_cycle();
    bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0300;
    wait_gnt(gi, gl);
    check("t6_gnt_if", gi, 1'b1);
    next_cycle(); bus.if_req_i = 0; bus.mem_ready_i = 1;
    next_cycle(); bus.mem_ready_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_ABCD;
    bus.ls_req_i = 1; bus.ls_wen_i = 0; bus.ls_addr_i = 32'h8000_4000; bus.ls_wmask_i = 4'b1111;
    neg();
    check("t6_if_rvalid", bus.if_rvalid_o, 1'b1);
    check("t6_if_rdata", bus.if_rdata_o, 32'h0000_ABCD);
    check("t6_ls_gnt_early", bus.ls_gnt_o, 1'b0);
    next_cycle(); bus.mem_rvalid_i = 0;
    neg();
    check("t6_ls_gnt", bus.ls_gnt_o, 1'b1);
    serve(1, 32'h99);
    bus.ls_req_i = 0;
    next_cycle();
    next_cycle();

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
